dsp_mac_sequencer: RTL and testbench

- Controller that sequences one DSP48A1 slice as a signed multiply-accumulate engine for dot products.
- Accepts a job length, then a valid/ready stream of 18-bit operand pairs. Drives the slice's A, B, OPMODE, CE and RST, and returns the 48-bit accumulated P with a valid/ready handshake.
- Sits between operand-producing logic and a single DSP48A1 instance. It tracks in-flight slots so that input stalls never corrupt the accumulator.

---
 rtl/dsp_mac_sequencer.sv | 142 ++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// Sequences a single DSP48A1 slice as a signed multiply-accumulate engine for dot products.
// A per-slot tag pipeline keeps OPMODE and result capture aligned with the slice latency.
module dsp_mac_sequencer #(
  parameter int unsigned LEN_W   = 10,
  parameter int unsigned LAT     = 4,
  parameter int unsigned OP_SKEW = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic [17:0]      a_in,
  input  logic [17:0]      b_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [47:0]      res,
  output logic             res_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_OPMODE,
  output logic             dsp_CE,
  output logic             dsp_RST,
  input  logic [47:0]      dsp_P,
  input  logic             dsp_CARRYOUT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } tag_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             first_pend;
  tag_t             tags      [0:LAT];
  tag_t             tags_next [0:LAT];
  tag_t             new_tag;
  logic             beat;
  logic             last_beat;
  logic             tail;

  assign busy      = (state != IDLE);
  assign in_ready  = (state == RUN);
  assign res_valid = (state == DONE);
  assign dsp_CE    = (state == RUN) || (state == DRAIN);
  assign dsp_RST   = RST;

  assign beat      = in_valid & in_ready;
  assign last_beat = beat && (remaining == LEN_W'(1));
  assign tail      = tags[LAT].v & tags[LAT].last;

  function automatic logic [7:0] opmode_of(input tag_t t);
    logic [7:0] op;
    if (!t.v)
      op = 8'b0000_1000;
    else if (t.first)
      op = 8'b0000_0001;
    else
      op = 8'b0000_1001;
    return op;
  endfunction

  // tags[k] describes the slot issued k cycles ago; tags[0] travels with dsp_A/dsp_B.
  always_comb begin
    new_tag.v     = beat;
    new_tag.first = beat & first_pend;
    new_tag.last  = last_beat;
    tags_next[0]  = new_tag;
    for (int unsigned k = 1; k <= LAT; k++)
      tags_next[k] = tags[k-1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      remaining  <= '0;
      first_pend <= 1'b0;
      res        <= '0;
      res_carry  <= 1'b0;
      dsp_A      <= '0;
      dsp_B      <= '0;
      dsp_OPMODE <= '0;
      for (int unsigned k = 0; k <= LAT; k++)
        tags[k] <= '0;
    end else begin
      for (int unsigned k = 0; k <= LAT; k++)
        tags[k] <= tags_next[k];
      dsp_A <= beat ? a_in : '0;
      dsp_B <= beat ? b_in : '0;
      // Registered so the port shows the OPMODE of the slot at stage OP_SKEW this cycle.
      dsp_OPMODE <= opmode_of(tags_next[OP_SKEW]);

      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              res       <= '0;
              res_carry <= 1'b0;
              state     <= DONE;
            end else begin
              remaining  <= len;
              first_pend <= 1'b1;
              state      <= RUN;
            end
          end
        end
        RUN: begin
          if (beat) begin
            remaining  <= remaining - LEN_W'(1);
            first_pend <= 1'b0;
            if (last_beat)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (tail) begin
            res       <= dsp_P;
            res_carry <= dsp_CARRYOUT;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice (LAT=4, OP_SKEW=1).
module tb_dsp_mac_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [9:0]  len;
  logic        busy;
  logic [17:0] a_in;
  logic [17:0] b_in;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] res;
  logic        res_carry;
  logic        res_valid;
  logic        res_ready;
  logic [17:0] dsp_A;
  logic [17:0] dsp_B;
  logic [7:0]  dsp_OPMODE;
  logic        dsp_CE;
  logic        dsp_RST;
  logic [47:0] dsp_P;
  logic        dsp_CARRYOUT;

  dsp_mac_sequencer #(.LEN_W(10), .LAT(4), .OP_SKEW(1)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy),
    .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready),
    .res(res), .res_carry(res_carry), .res_valid(res_valid), .res_ready(res_ready),
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE), .dsp_CE(dsp_CE),
    .dsp_RST(dsp_RST), .dsp_P(dsp_P), .dsp_CARRYOUT(dsp_CARRYOUT)
  );

  always #5 CLK = ~CLK;

  // Slice model: A/B -> M pipeline of 3 regs, OPMODE delayed 2 regs, then P register.
  logic signed [35:0] prod;
  logic [47:0] m1, m2, m3, p_q;
  logic [7:0]  o1, o2;
  logic        c_q;
  logic [47:0] xm, zm;
  logic [48:0] sum;

  always_comb begin
    prod = $signed(dsp_A) * $signed(dsp_B);
    xm   = (o2[1:0] == 2'b01) ? m3 : 48'd0;
    zm   = (o2[3:2] == 2'b10) ? p_q : 48'd0;
    sum  = {1'b0, xm} + {1'b0, zm};
  end

  always @(posedge CLK) begin
    if (dsp_RST) begin
      m1 <= '0; m2 <= '0; m3 <= '0; o1 <= '0; o2 <= '0; p_q <= '0; c_q <= 1'b0;
    end else if (dsp_CE) begin
      m1  <= {{12{prod[35]}}, prod};
      m2  <= m1;
      m3  <= m2;
      o1  <= dsp_OPMODE;
      o2  <= o1;
      p_q <= sum[47:0];
      c_q <= sum[48];
    end
  end

  assign dsp_P        = p_q;
  assign dsp_CARRYOUT = c_q;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        logging = 1'b0;
  logic        ce_seen = 1'b0;
  logic        rv_seen = 1'b0;
  logic [7:0]  oplog[$];
  logic [17:0] va [0:3];
  logic [17:0] vb [0:3];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (dsp_CE) ce_seen = 1'b1;
    if (res_valid) rv_seen = 1'b1;
    if (logging && dsp_CE) oplog.push_back(dsp_OPMODE);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one job from IDLE; returns with res_valid observed (or the bound expired).
  task automatic do_job(input int n, input int gap, output int lat);
    int bcyc;
    int w;
    bcyc = cyc;
    start = 1'b1;
    len   = 10'(n);
    tick;
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (gap > 0 && k > 0) begin
        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (gap) tick;
      end
      a_in = va[k];
      b_in = vb[k];
      in_valid = 1'b1;
      check("in_ready_at_beat", 64'(in_ready), 64'd1);
      bcyc = cyc;
      tick;
    end
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    w = 0;
    while (!res_valid && w < 50) begin
      tick;
      w++;
    end
    lat = cyc - bcyc;
    check("res_valid_reached", 64'(res_valid), 64'd1);
  endtask

  // Checks the logged OPMODE stream: slots 01,09,09 with the given bubble count between them.
  task automatic check_ops(input int bubbles);
    int nz;
    int first_i;
    int last_i;
    int inner08;
    int bad;
    logic [7:0] seq [0:2];
    nz = 0; first_i = -1; last_i = -1; inner08 = 0; bad = 0;
    for (int i = 0; i < oplog.size(); i++) begin
      if (oplog[i] != 8'h08) begin
        if (nz < 3) seq[nz] = oplog[i];
        if (first_i < 0) first_i = i;
        last_i = i;
        nz++;
      end
      if (oplog[i] != 8'h01 && oplog[i] != 8'h08 && oplog[i] != 8'h09) bad++;
    end
    for (int i = first_i; i <= last_i && first_i >= 0; i++)
      if (oplog[i] == 8'h08) inner08++;
    check("op_slot_count", 64'(nz), 64'd3);
    check("op_illegal", 64'(bad), 64'd0);
    if (nz == 3) begin
      check("op_seq0", 64'(seq[0]), 64'h01);
      check("op_seq1", 64'(seq[1]), 64'h09);
      check("op_seq2", 64'(seq[2]), 64'h09);
    end
    check("op_bubbles", 64'(inner08), 64'(bubbles));
  endtask

  initial begin
    int lat;
    longint ref_sum;
    logic [47:0] exp48;
    logic [47:0] held;

    RST = 1'b1; start = 1'b0; len = '0; a_in = '0; b_in = '0;
    in_valid = 1'b0; res_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); len = 10'($urandom); a_in = 18'($urandom);
      b_in = 18'($urandom); in_valid = 1'($urandom); res_ready = 1'($urandom);
      tick;
    end
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_res_carry", 64'(res_carry), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_dsp_A", 64'(dsp_A), 64'd0);
    check("rst_dsp_B", 64'(dsp_B), 64'd0);
    check("rst_opmode", 64'(dsp_OPMODE), 64'd0);
    check("rst_ce", 64'(dsp_CE), 64'd0);
    check("rst_dsp_rst", 64'(dsp_RST), 64'd1);
    RST = 1'b0; start = 1'b0; len = '0; a_in = '0; b_in = '0;
    in_valid = 1'b0; res_ready = 1'b0;
    tick;
    check("post_rst_dsp_rst", 64'(dsp_RST), 64'd0);
    tick;

    // len=1: 20*10
    va[0] = 18'd20; vb[0] = 18'd10;
    res_ready = 1'b1;
    do_job(1, 0, lat);
    check("len1_latency", 64'(lat), 64'd6);
    check("len1_res", 64'(res), 64'h0000_0000_00C8);
    check("len1_carry", 64'(res_carry), 64'd0);
    tick;
    check("len1_valid_one_cycle", 64'(res_valid), 64'd0);
    check("len1_idle", 64'(busy), 64'd0);
    tick;

    // len=3, no stalls, result held while res_ready is low
    va[0] = 18'd5; vb[0] = 18'd6;
    va[1] = 18'd2; vb[1] = 18'd3;
    va[2] = 18'h3FFFF; vb[2] = 18'd4;
    res_ready = 1'b0;
    oplog.delete();
    logging = 1'b1;
    do_job(3, 0, lat);
    logging = 1'b0;
    check("dot3_res", 64'(res), 64'h20);
    check("dot3_carry", 64'(res_carry), 64'd1);
    held = res;
    start = 1'b1; len = 10'd5;
    repeat (3) tick;
    start = 1'b0;
    check("done_hold_valid", 64'(res_valid), 64'd1);
    check("done_hold_in_ready", 64'(in_ready), 64'd0);
    check("done_hold_res", 64'(res), 64'(held));
    check("done_ignores_start_ce", 64'(dsp_CE), 64'd0);
    res_ready = 1'b1;
    tick;
    check("done_release", 64'(res_valid), 64'd0);
    check_ops(0);
    tick;

    // Same job with 2-cycle input stalls between pairs
    oplog.delete();
    logging = 1'b1;
    do_job(3, 2, lat);
    logging = 1'b0;
    check("stall_res", 64'(res), 64'h20);
    check("stall_carry", 64'(res_carry), 64'd1);
    tick;
    check_ops(4);
    tick;

    // Extreme operands, accumulated twice
    va[0] = 18'h20000; vb[0] = 18'h1FFFF;
    va[1] = 18'h20000; vb[1] = 18'h1FFFF;
    ref_sum = longint'(-131072) * longint'(131071) * 2;
    exp48 = ref_sum[47:0];
    do_job(2, 0, lat);
    check("ext_res", 64'(res), 64'(exp48));
    check("ext_res_hand", 64'(res), 64'hFFF8_0004_0000);
    check("ext_carry", 64'(res_carry), 64'd1);
    tick;
    tick;

    // len=0: straight to DONE with zero result, slice never enabled
    ce_seen = 1'b0;
    res_ready = 1'b0;
    start = 1'b1; len = 10'd0;
    tick;
    start = 1'b0;
    check("len0_valid", 64'(res_valid), 64'd1);
    check("len0_res", 64'(res), 64'd0);
    check("len0_carry", 64'(res_carry), 64'd0);
    res_ready = 1'b1;
    tick;
    check("len0_idle", 64'(busy), 64'd0);
    check("len0_no_ce", 64'(ce_seen), 64'd0);
    tick;

    // Reset mid-RUN after 2 of 4 beats
    start = 1'b1; len = 10'd4;
    tick;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a_in = 18'd7; b_in = 18'd7; in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0; a_in = '0; b_in = '0;
    check("abort_was_running", 64'(busy), 64'd1);
    RST = 1'b1;
    tick;
    RST = 1'b0;
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_ce", 64'(dsp_CE), 64'd0);
    rv_seen = 1'b0;
    repeat (10) tick;
    check("abort_no_result", 64'(rv_seen), 64'd0);
    va[0] = 18'd3; vb[0] = 18'd3;
    do_job(1, 0, lat);
    check("after_abort_res", 64'(res), 64'd9);
    check("after_abort_carry", 64'(res_carry), 64'd0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
